// File: rtl/srsw_raddr_pkg.sv
// Shared constants for the single-read single-write registered-address memory.
package srsw_raddr_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 2;

   // Number of words addressed by an address of the given width
   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'(1) << aw;
   endfunction

endpackage : srsw_raddr_pkg

// File: rtl/srsw_raddr_array.sv
// Storage array with a single synchronous write port; all words exposed for the read mux.
module srsw_raddr_array
   import srsw_raddr_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         wen,
   input  logic [ADDR_WIDTH-1:0]                        waddr,
   input  logic [DATA_WIDTH-1:0]                        wdata,
   output logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   mem
);

   localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

   // Write port; reset clears every word and discards a concurrent write
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
      end else if (wen) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign mem = mem_q;

endmodule : srsw_raddr_array

// File: rtl/srsw_raddr.sv
// Single-read single-write memory with a registered read address and combinational read data.
module srsw_raddr
   import srsw_raddr_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  ren,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_words;
   logic [ADDR_WIDTH-1:0]            raddr_q;

   srsw_raddr_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .wen   (wen),
      .waddr (waddr),
      .wdata (wdata),
      .mem   (mem_words)
   );

   // Read-address register: loads on ren, holds otherwise, clears on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         raddr_q <= '0;
      end else if (ren) begin
         raddr_q <= raddr;
      end
   end

   // Unregistered read so a write to the held address shows up right after its edge
   always_comb begin
      rdata = mem_words[raddr_q];
   end

endmodule : srsw_raddr

// File: tb/tb_srsw_raddr.sv
// Scoreboard bench for srsw_raddr: stimulus pushes expected rdata, a monitor pops and compares.
module tb_srsw_raddr;
   import srsw_raddr_pkg::*;

   localparam int unsigned DW = DEF_DATA_WIDTH;
   localparam int unsigned AW = DEF_ADDR_WIDTH;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          clk_en = 1'b1;
   logic          rst = 1'b1;
   logic          wen = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [DW-1:0] wdata = '0;
   logic          ren = 1'b0;
   logic [AW-1:0] raddr = '0;
   logic [DW-1:0] rdata;
   logic          pause_tick = 1'b0;

   logic [DW-1:0] mdl_mem [DEPTH];
   logic [AW-1:0] mdl_ra;

   logic [DW-1:0] exp_q [$];
   string         name_q [$];

   int n_cmp = 0;
   int n_bad = 0;

   srsw_raddr #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .wen   (wen),
      .waddr (waddr),
      .wdata (wdata),
      .ren   (ren),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Gateable clock, 10 time-unit period
   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   // Monitor: compare rdata just after every rising edge or pause sample point
   initial begin
      logic [DW-1:0] e;
      string         nm;
      forever begin
         @(posedge clk or posedge pause_tick);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (rdata !== e) begin
               n_bad++;
               $display("FAIL %s: rdata=%h expected=%h at t=%0t", nm, rdata, e, $time);
            end
         end
      end
   end

   // Drive one cycle, advance the model, push the rdata expected after the edge
   task automatic cyc(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input string nm);
      rst = r; wen = we; waddr = wa; wdata = wd; ren = re; raddr = ra;
      if (r) begin
         for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
         mdl_ra = '0;
      end else begin
         if (we) mdl_mem[wa] = wd;
         if (re) mdl_ra = ra;
      end
      exp_q.push_back(mdl_mem[mdl_ra]);
      name_q.push_back(nm);
      @(negedge clk);
   endtask

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset (two edges) with writes/reads requested during reset
      cyc(1'b1, 1'b1, 2'd1, 32'h1111_1111, 1'b1, 2'd1, "reset0");
      cyc(1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 2'd0, "reset1");

      cyc(1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 2'd2, "rd_after_reset");
      cyc(1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF, 1'b0, 2'd0, "write_other_addr");
      cyc(1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 2'd1, "read_deadbeef");
      cyc(1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 2'd3, "read_addr3_zero");
      cyc(1'b0, 1'b1, 2'd3, 32'h1234_5678, 1'b0, 2'd0, "write_held_addr");
      cyc(1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 2'd1, "hold_no_ren");
      cyc(1'b0, 1'b1, 2'd0, 32'hA5A5_A5A5, 1'b1, 2'd0, "same_edge_rw");
      cyc(1'b0, 1'b1, 2'd2, 32'hCAFE_F00D, 1'b1, 2'd1, "read1_write2");
      cyc(1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 2'd2, "read_cafef00d");
      cyc(1'b0, 1'b1, 2'd1, 32'h0BAD_F00D, 1'b1, 2'd3, "overwrite1_read3");
      cyc(1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 2'd1, "read_overwritten");

      // Pause: clock held low for 10 periods while inputs wander
      clk_en = 1'b0;
      #1;
      for (int i = 0; i < 10; i++) begin
         wen   = 1'($urandom_range(0, 1));
         waddr = AW'($urandom_range(0, DEPTH - 1));
         wdata = DW'($urandom);
         ren   = 1'($urandom_range(0, 1));
         raddr = AW'($urandom_range(0, DEPTH - 1));
         rst   = 1'($urandom_range(0, 1));
         exp_q.push_back(mdl_mem[mdl_ra]);
         name_q.push_back("paused_hold");
         pause_tick = 1'b1;
         #5;
         pause_tick = 1'b0;
         #5;
      end
      clk_en = 1'b1;

      // Random traffic checked every cycle against the model
      for (int i = 0; i < 500; i++) begin
         cyc(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), "random");
      end

      // Mid-operation reset with a concurrent write to address 2
      cyc(1'b0, 1'b1, 2'd2, 32'h5555_AAAA, 1'b1, 2'd2, "prefill2");
      cyc(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b1, 2'd2, "reset_with_write");
      cyc(1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 2'd2, "read2_after_reset");
      for (int a = 0; a < DEPTH; a++) begin
         cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, AW'(a), "all_zero_after_reset");
      end

      cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, "idle_end");
      @(negedge clk);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_srsw_raddr
